// File: rtl/adder_pipe_pkg.sv
// Shared types and helpers for the adder pipeline flow-control wrapper.
// Holds default geometry, the controller state encoding and saturating arithmetic.
package adder_pipe_pkg;

    localparam int WORD_WIDTH_DEF = 4;
    localparam int LAYERS_DEF     = 3;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_t;

    // Adds b to a and clamps the result to the largest w-bit value (w < 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] s;
        logic [32:0] m;
        m = (33'd1 << w) - 33'd1;
        s = {1'b0, a} + {1'b0, b};
        return (s > m) ? m[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/pipe_stall_chain.sv
// Combinational advance/hold chain: a layer may move when it is empty or
// when the layer after it moves; the last layer moves when downstream is ready.
module pipe_stall_chain
    import adder_pipe_pkg::*;
#(
    parameter int LAYERS = LAYERS_DEF
) (
    input  logic [LAYERS-1:0] occ,
    input  logic              out_ready,
    output logic [LAYERS-1:0] adv,
    output logic [LAYERS-1:0] pipe_hold
);

    logic w_carry;

    // Ripple from the output end back to the input end.
    always_comb begin
        adv     = '0;
        w_carry = out_ready;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            w_carry = ~occ[i] | w_carry;
            adv[i]  = w_carry;
        end
    end

    assign pipe_hold = ~adv;

endmodule

// File: rtl/adder_pipeline_ctrl.sv
// Valid/ready flow control and alarm recovery around the parity-protected
// cascaded adder pipeline: tracks per-layer tokens and scrubs on alarm or reset.
module adder_pipeline_ctrl
    import adder_pipe_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int LAYERS     = LAYERS_DEF,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic [WORD_WIDTH-1:0] pipe_input_vector,
    output logic [LAYERS-1:0]     pipe_hold,
    input  logic [WORD_WIDTH-1:0] pipe_sum,
    input  logic                  pipe_alarm,
    output logic                  err_flag,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [ERR_CNT_W-1:0]  drop_cnt
);

    localparam int FCNT_W = $clog2(LAYERS + 1);
    localparam logic [FCNT_W-1:0] FLUSH_LEN = FCNT_W'(LAYERS);

    ctrl_state_t           r_state;
    logic [FCNT_W-1:0]     r_flush_cnt;
    logic [LAYERS-1:0]     r_occ;
    logic                  r_err_flag;
    logic [ERR_CNT_W-1:0]  r_err_cnt;
    logic [ERR_CNT_W-1:0]  r_drop_cnt;

    logic [LAYERS-1:0]     w_adv;
    logic [LAYERS-1:0]     w_hold;
    logic                  w_run;
    logic                  w_in_hs;

    pipe_stall_chain #(
        .LAYERS(LAYERS)
    ) u_stall (
        .occ      (r_occ),
        .out_ready(out_ready),
        .adv      (w_adv),
        .pipe_hold(w_hold)
    );

    assign w_run             = (r_state == RUN);
    assign in_ready          = w_run & w_adv[0];
    // The alarm masks the output combinationally so a corrupt word never hands off.
    assign out_valid         = w_run & r_occ[LAYERS-1] & ~pipe_alarm;
    assign pipe_hold         = w_run ? w_hold : '0;
    assign w_in_hs           = in_valid & in_ready;
    assign pipe_input_vector = in_data;
    assign out_data          = pipe_sum;
    assign err_flag          = r_err_flag;
    assign err_cnt           = r_err_cnt;
    assign drop_cnt          = r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FLUSH;
            r_flush_cnt <= FLUSH_LEN;
            r_occ       <= '0;
            r_err_flag  <= 1'b0;
            r_err_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (pipe_alarm) begin
                        r_state     <= FLUSH;
                        r_flush_cnt <= FLUSH_LEN;
                        r_occ       <= '0;
                        r_err_flag  <= 1'b1;
                        r_err_cnt   <= ERR_CNT_W'(sat_add(32'(r_err_cnt), 32'd1, ERR_CNT_W));
                        // Every in-flight token plus a word accepted this very cycle is lost.
                        r_drop_cnt  <= ERR_CNT_W'(sat_add(32'(r_drop_cnt),
                                                          32'($countones(r_occ)) + 32'(w_in_hs),
                                                          ERR_CNT_W));
                    end else begin
                        if (w_adv[0]) begin
                            r_occ[0] <= w_in_hs;
                        end
                        for (int i = 1; i < LAYERS; i++) begin
                            if (w_adv[i]) begin
                                r_occ[i] <= r_occ[i-1];
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (r_flush_cnt <= FCNT_W'(1)) begin
                        r_state <= RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state     <= FLUSH;
                    r_flush_cnt <= FLUSH_LEN;
                end
            endcase
        end
    end

endmodule
